// File: rtl/bbox_overlay.sv
// Draws a rectangular outline of the tracked bounding box onto a FIFO-to-FIFO RGB
// pixel stream with zero added latency; box changes are applied only at frame ends.
module bbox_overlay #(
  parameter int          WIDTH     = 720,
  parameter int          HEIGHT    = 540,
  parameter int          THICK     = 2,
  parameter logic [23:0] COLOR     = 24'h00FF00,
  parameter int          MAX_STALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        box_valid,
  input  logic [11:0] center_x,
  input  logic [11:0] center_y,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic        in_empty,
  output logic        in_rd_en,
  input  logic [23:0] in_dout,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [23:0] out_din,
  output logic        frame_done
);

  localparam int          SW    = $clog2(MAX_STALE + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STALE);
  localparam logic [12:0] XMAX  = 13'(WIDTH - 1);
  localparam logic [12:0] YMAX  = 13'(HEIGHT - 1);
  localparam logic [13:0] TH    = 14'(THICK);

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [12:0] l;
    logic [12:0] r;
    logic [12:0] t;
    logic [12:0] b;
  } box_t;

  state_t        state_q, state_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic [SW-1:0] stale_q, stale_d, stale_inc;
  logic          pend_v_q, pend_v_d, pend_clr_q, pend_clr_d;
  box_t          pend_q, pend_d, act_q, act_d;
  logic          frame_done_q, frame_done_d;

  logic          xfer, x_last, y_last, last_px;
  logic [12:0]   hw, hh, cx, cy, sum_x, sum_y;
  box_t          new_box;
  logic          new_clr;
  logic [13:0]   x_e, y_e, l_e, r_e, t_e, b_e;
  logic          in_box, near_side, on_edge;

  assign xfer      = !in_empty && !out_full && !reset;
  assign in_rd_en  = xfer;
  assign out_wr_en = xfer;
  assign x_last    = (x_q == 12'(WIDTH - 1));
  assign y_last    = (y_q == 12'(HEIGHT - 1));
  assign last_px   = xfer && x_last && y_last;

  // Incoming box, clamped to the frame; 13-bit sums cannot overflow.
  always_comb begin
    hw        = {2'b00, width[11:1]};
    hh        = {2'b00, height[11:1]};
    cx        = {1'b0, center_x};
    cy        = {1'b0, center_y};
    sum_x     = cx + hw;
    sum_y     = cy + hh;
    new_box.l = (cx >= hw) ? cx - hw : 13'd0;
    new_box.r = (sum_x > XMAX) ? XMAX : sum_x;
    new_box.t = (cy >= hh) ? cy - hh : 13'd0;
    new_box.b = (sum_y > YMAX) ? YMAX : sum_y;
    new_clr   = (width == 12'd0) || (height == 12'd0);
  end

  // Outline test against the committed box only, never the pending one.
  assign x_e = {2'b00, x_q};
  assign y_e = {2'b00, y_q};
  assign l_e = {1'b0, act_q.l};
  assign r_e = {1'b0, act_q.r};
  assign t_e = {1'b0, act_q.t};
  assign b_e = {1'b0, act_q.b};

  assign in_box    = (x_e >= l_e) && (x_e <= r_e) && (y_e >= t_e) && (y_e <= b_e);
  assign near_side = (x_e < l_e + TH) || (x_e + TH > r_e) ||
                     (y_e < t_e + TH) || (y_e + TH > b_e);
  assign on_edge   = (state_q == ACTIVE) && in_box && near_side;

  assign out_din    = on_edge ? COLOR : in_dout;
  assign frame_done = frame_done_q;

  assign stale_inc = (stale_q == SMAX) ? stale_q : stale_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    stale_d      = stale_q;
    pend_v_d     = pend_v_q;
    pend_clr_d   = pend_clr_q;
    pend_d       = pend_q;
    act_d        = act_q;
    frame_done_d = last_px;

    if (xfer) begin
      if (x_last) begin
        x_d = 12'd0;
        y_d = y_last ? 12'd0 : y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end

    if (last_px) begin
      if (box_valid) begin
        // A box arriving on the last pixel bypasses the pending slot.
        act_d    = new_box;
        state_d  = new_clr ? IDLE : ACTIVE;
        stale_d  = '0;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        act_d    = pend_q;
        state_d  = pend_clr_q ? IDLE : ACTIVE;
        stale_d  = '0;
        pend_v_d = 1'b0;
      end else begin
        stale_d = stale_inc;
        if (stale_inc == SMAX) state_d = IDLE;
      end
    end else if (box_valid) begin
      pend_d     = new_box;
      pend_clr_d = new_clr;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      stale_q      <= '0;
      pend_v_q     <= 1'b0;
      pend_clr_q   <= 1'b0;
      pend_q       <= '0;
      act_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      stale_q      <= stale_d;
      pend_v_q     <= pend_v_d;
      pend_clr_q   <= pend_clr_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bbox_overlay.sv
// Scoreboard bench for bbox_overlay on a reduced 32x12 frame: a frame-level reference
// model predicts each transferred pixel, which is compared as the DUT writes it out.
module tb_bbox_overlay;
  localparam int          W   = 32;
  localparam int          H   = 12;
  localparam int          TH  = 2;
  localparam int          MS  = 2;
  localparam logic [23:0] COL = 24'h00FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        box_valid = 1'b0;
  logic [11:0] center_x = '0, center_y = '0, width = '0, height = '0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [23:0] in_dout = '0;
  logic        out_full = 1'b0;
  logic        out_wr_en;
  logic [23:0] out_din;
  logic        frame_done;

  bbox_overlay #(.WIDTH(W), .HEIGHT(H), .THICK(TH), .COLOR(COL), .MAX_STALE(MS)) dut (
    .clock(clk), .reset(reset), .box_valid(box_valid),
    .center_x(center_x), .center_y(center_y), .width(width), .height(height),
    .in_empty(in_empty), .in_rd_en(in_rd_en), .in_dout(in_dout),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state (position, committed box, pending box, staleness).
  int mx = 0, my = 0;
  bit m_act = 0;
  int ml = 0, mr = 0, mt = 0, mb = 0;
  bit m_pv = 0, m_pclr = 0;
  int pl = 0, pr = 0, pt = 0, pb = 0;
  int m_stale = 0;
  bit fd_pending = 0, exp_fd = 0, exp_xfer = 0;
  int exp_x = 0, exp_y = 0;
  logic [23:0] exp_q[$];
  int pix = 0;
  int wr_cnt = 0, fd_cnt = 0;

  function automatic void calc(input int cx, input int cy, input int w, input int h,
                               output int l, output int r, output int t, output int b,
                               output bit clr);
    int hw, hh;
    hw  = w / 2;
    hh  = h / 2;
    l   = (cx >= hw) ? cx - hw : 0;
    r   = (cx + hw > W - 1) ? W - 1 : cx + hw;
    t   = (cy >= hh) ? cy - hh : 0;
    b   = (cy + hh > H - 1) ? H - 1 : cy + hh;
    clr = (w == 0) || (h == 0);
  endfunction

  // Outline = inside the outer rectangle but not strictly inside the inner one.
  function automatic bit model_edge(input int x, input int y);
    bit outer, inner;
    outer = (x >= ml) && (x <= mr) && (y >= mt) && (y <= mb);
    inner = (x >= ml + TH) && (x <= mr - TH) && (y >= mt + TH) && (y <= mb - TH);
    return m_act && outer && !inner;
  endfunction

  task automatic cyc(input bit bv, input int cx, input int cy, input int w, input int h,
                     input bit emp, input bit full, input bit rst);
    bit xf, last, nclr;
    int nl, nr, nt, nb;
    @(posedge clk);
    #1;
    exp_fd    = fd_pending;
    reset     = rst;
    box_valid = bv;
    center_x  = 12'(cx);
    center_y  = 12'(cy);
    width     = 12'(w);
    height    = 12'(h);
    in_empty  = emp;
    out_full  = full;
    in_dout   = pix[23:0];
    xf        = !emp && !full && !rst;
    exp_xfer  = xf;
    exp_x     = mx;
    exp_y     = my;
    if (xf) begin
      exp_q.push_back(model_edge(mx, my) ? COL : pix[23:0]);
      pix++;
    end
    if (rst) begin
      mx = 0; my = 0; m_act = 0; m_pv = 0; m_stale = 0; fd_pending = 0;
    end else begin
      calc(cx, cy, w, h, nl, nr, nt, nb, nclr);
      last       = xf && (mx == W - 1) && (my == H - 1);
      fd_pending = last;
      if (last) begin
        if (bv) begin
          ml = nl; mr = nr; mt = nt; mb = nb; m_act = !nclr; m_pv = 0; m_stale = 0;
        end else if (m_pv) begin
          ml = pl; mr = pr; mt = pt; mb = pb; m_act = !m_pclr; m_pv = 0; m_stale = 0;
        end else begin
          if (m_stale < MS) m_stale++;
          if (m_stale == MS) m_act = 0;
        end
      end else if (bv) begin
        pl = nl; pr = nr; pt = nt; pb = nb; m_pclr = nclr; m_pv = 1;
      end
      if (xf) begin
        mx++;
        if (mx == W) begin
          mx = 0;
          my++;
          if (my == H) my = 0;
        end
      end
    end
  endtask

  task automatic run_px(input int n, input bit stalls);
    int done;
    bit e, f;
    done = 0;
    while (done < n) begin
      e = 0;
      f = 0;
      if (stalls) begin
        e = ($urandom_range(0, 5) == 0);
        f = ($urandom_range(0, 5) == 0);
      end
      cyc(0, 0, 0, 0, 0, e, f, 0);
      if (!e && !f) done++;
    end
  endtask

  task automatic to_pos(input int x, input int y);
    run_px(((y * W + x) - (my * W + mx) + W * H) % (W * H), 0);
  endtask

  task automatic finish_frame(input bit stalls);
    run_px(W * H - (my * W + mx), stalls);
  endtask

  task automatic box_px(input int cx, input int cy, input int w, input int h);
    cyc(1, cx, cy, w, h, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    check_val("in_rd_en", 32'(in_rd_en), 32'(exp_xfer));
    check_val("out_wr_en", 32'(out_wr_en), 32'(exp_xfer));
    check_val("frame_done", 32'(frame_done), 32'(exp_fd));
    if (exp_xfer) begin
      check_val("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0)
        check_val($sformatf("pix(%0d,%0d)", exp_x, exp_y), 32'(out_din), 32'(exp_q.pop_front()));
    end
    if (out_wr_en) wr_cnt++;
    if (frame_done) fd_cnt++;
  end

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1);

    wr_cnt = 0;
    fd_cnt = 0;
    run_px(W * H, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    check_val("pass_writes", 32'(wr_cnt), 32'(W * H));
    check_val("pass_frame_done", 32'(fd_cnt), 32'd1);
    $display("passthrough frame: %0d writes, %0d frame_done", wr_cnt, fd_cnt);

    to_pos(5, 1);
    box_px(16, 5, 8, 6);
    finish_frame(0);
    $display("draw: box cx=16 cy=5 w=8 h=6 queued");
    to_pos(10, 3);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    finish_frame(0);
    $display("draw frame 1 with out_full x5 / in_empty x3 stalls");
    finish_frame(1);
    finish_frame(1);
    $display("stale: frame 2 drawn, frame 3 passthrough");

    box_px(2, 6, 10, 4);
    finish_frame(0);
    box_px(30, 3, 8, 4);
    finish_frame(0);
    finish_frame(0);
    $display("clamp: left-edge and right-edge boxes");

    box_px(16, 6, 10, 6);
    finish_frame(0);
    to_pos(3, 2);
    box_px(16, 6, 0, 6);
    finish_frame(0);
    finish_frame(0);
    $display("clear: w=0 box drops outline");

    to_pos(W - 1, H - 1);
    box_px(8, 8, 6, 5);
    finish_frame(0);
    $display("boundary: box on last pixel drawn next frame");

    to_pos(5, 2);
    box_px(20, 4, 10, 4);
    to_pos(10, 5);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    finish_frame(0);
    $display("reset at (10,5): next frame passthrough");

    repeat (7) begin
      int cx, cy, w, h;
      cx = $urandom_range(0, 40);
      cy = $urandom_range(0, 15);
      w  = $urandom_range(0, 20);
      h  = $urandom_range(0, 12);
      run_px($urandom_range(0, W * H - 1), 1);
      cyc(1, cx, cy, w, h, $urandom_range(0, 1) == 1, 0, 0);
      finish_frame(1);
      $display("random: box cx=%0d cy=%0d w=%0d h=%0d", cx, cy, w, h);
    end

    repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    check_val("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
